bit_serial_psum_acc: RTL

Bit-serial partial-sum accumulator controller for the PE datapath. Accepts a stream of signed operands over a valid/ready handshake and adds each one into a running psum one bit per cycle, LSB first, through a single one-bit full-adder cell. When the operand flagged last has been added, it presents the psum plus a sticky overflow flag on a valid/ready output port. The block trades adder area for latency and sits between the PE's multiplier output and the psum NoC port.

---
 rtl/bit_serial_psum_acc_pkg.sv | 23 ++
 rtl/bit_serial_psum_acc_fa.sv | 13 +
 rtl/bit_serial_psum_acc.sv | 123 ++++++++++++
 3 files changed

// File: rtl/bit_serial_psum_acc_pkg.sv
// Shared types and constants for the bit-serial psum accumulator.
// Saturation helpers are only referenced when BSPA_SATURATE_EN is defined.
package bspa_pkg;

    localparam int DATA_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        OUT  = 2'd2
    } state_e;

    // Most positive two's complement value of width w, zero-extended to 64 bits.
    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most negative two's complement value of width w (sign bit only).
    function automatic logic [63:0] sat_min(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/bit_serial_psum_acc_fa.sv
// One-bit full-adder cell shared by the bit-serial accumulator datapath.
module FA (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);

    assign sum_o  = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/bit_serial_psum_acc.sv
// Bit-serial partial-sum accumulator: one FA adds each operand LSB-first into acc.
// Optional feature macro: BSPA_SATURATE_EN (saturate on signed overflow instead of wrapping).
module bit_serial_psum_acc
    import bspa_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         out_ovf
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

`ifdef BSPA_SATURATE_EN
    localparam logic [DATA_WIDTH-1:0] SAT_MAX = DATA_WIDTH'(sat_max(DATA_WIDTH));
    localparam logic [DATA_WIDTH-1:0] SAT_MIN = DATA_WIDTH'(sat_min(DATA_WIDTH));
`endif

    state_e                state_q;
    logic [DATA_WIDTH-1:0] acc_q;
    logic [DATA_WIDTH-1:0] acc_d;
    logic [DATA_WIDTH-1:0] op_q;
    logic                  carry_q;
    logic [CW-1:0]         cnt_q;
    logic                  last_q;
    logic                  ovf_q;
    logic                  out_valid_q;

    logic sum_bit;
    logic cout_bit;
    logic msb_step;
    logic step_ovf;

    FA u_fa (
        .a_i    (op_q[0]),
        .b_i    (acc_q[0]),
        .cin_i  (carry_q),
        .sum_o  (sum_bit),
        .cout_o (cout_bit)
    );

    assign msb_step = (cnt_q == CNT_LAST);
    // Signed overflow shows up as a carry disagreement across the sign bit.
    assign step_ovf = carry_q ^ cout_bit;

    always_comb begin
        acc_d = {sum_bit, acc_q[DATA_WIDTH-1:1]};
`ifdef BSPA_SATURATE_EN
        // On the sign-bit step op_q[0] holds the operand's sign, which picks the rail.
        if (msb_step && step_ovf) begin
            acc_d = op_q[0] ? SAT_MIN : SAT_MAX;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            op_q        <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            last_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_q    <= in_data;
                        last_q  <= in_last;
                        carry_q <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= ADD;
                    end
                end
                ADD: begin
                    acc_q   <= acc_d;
                    op_q    <= op_q >> 1;
                    carry_q <= cout_bit;
                    cnt_q   <= cnt_q + CW'(1);
                    if (msb_step) begin
                        ovf_q <= ovf_q | step_ovf;
                        cnt_q <= '0;
                        if (last_q) begin
                            state_q     <= OUT;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        acc_q       <= '0;
                        ovf_q       <= 1'b0;
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = acc_q;
    assign out_ovf   = ovf_q;

endmodule
